// File: rtl/encoder_pkg.sv
// Shared command-packet definitions for the UART encoder/decoder pair: sizes, field offsets,
// FSM state codes and the single packing function both sides use.
package encoder_pkg;

    localparam int PKG_DATA_BIT = 32;
    localparam int PKG_PACK_NUM = 11;
    localparam int PACK_BIT     = 8 * PKG_PACK_NUM;
    localparam int FREQ_INDEX   = 2 * PKG_DATA_BIT;

    // Control-field offsets relative to FREQ_INDEX
    localparam int START_OFS = 0;
    localparam int STOP_OFS  = 1;
    localparam int MODE_OFS  = 2;
    localparam int SEL_OFS   = 4;
    localparam int SLOW_OFS  = 8;
    localparam int FAST_OFS  = 16;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    function automatic logic [PACK_BIT-1:0] pack_cmd(
        input logic [PKG_DATA_BIT-1:0] out_pat,
        input logic [PKG_DATA_BIT-1:0] freq_pat,
        input logic                    start,
        input logic                    stop,
        input logic                    mode,
        input logic [3:0]              sel_out,
        input logic [7:0]              slow_period,
        input logic [7:0]              fast_period
    );
        logic [PACK_BIT-1:0] pkt;
        pkt                                  = '0;
        pkt[PKG_DATA_BIT-1:0]                = out_pat;
        pkt[FREQ_INDEX-1:PKG_DATA_BIT]       = freq_pat;
        pkt[FREQ_INDEX+START_OFS]            = start;
        pkt[FREQ_INDEX+STOP_OFS]             = stop;
        pkt[FREQ_INDEX+MODE_OFS]             = mode;
        pkt[FREQ_INDEX+SEL_OFS +: 4]         = sel_out;
        pkt[FREQ_INDEX+SLOW_OFS +: 8]        = slow_period;
        pkt[FREQ_INDEX+FAST_OFS +: 8]        = fast_period;
        return pkt;
    endfunction

endpackage

// File: rtl/encoder.sv
// Command-word serialiser for the UART transmitter, LSB byte first, one byte per start/done handshake.
// Optional CHECKSUM_EN appends an XOR byte of the payload; start ticks while busy are dropped.
module encoder
    import encoder_pkg::*;
#(
    parameter int DATA_BIT = PKG_DATA_BIT,
    parameter int PACK_NUM = PKG_PACK_NUM
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start_tick,
    input  logic [DATA_BIT-1:0] i_output_pattern,
    input  logic [DATA_BIT-1:0] i_freq_pattern,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic                i_mode,
    input  logic [3:0]          i_sel_out,
    input  logic [7:0]          i_slow_period,
    input  logic [7:0]          i_fast_period,
    input  logic                i_tx_done_tick,
    output logic [7:0]          o_tx_data,
    output logic                o_tx_start,
    output logic                o_busy,
    output logic                o_done_tick
);

    localparam int CNT_W = $clog2(PACK_NUM + 1);
`ifdef CHECKSUM_EN
    localparam int N_BYTES = PACK_NUM + 1;
`else
    localparam int N_BYTES = PACK_NUM;
`endif
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_BYTES - 1);

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [8*PACK_NUM-1:0] r_buf;
    logic [7:0]            r_tx_data;
    logic                  r_tx_start;
    logic                  r_busy;
    logic                  r_done_tick;
    logic [8*PACK_NUM-1:0] w_pkt;
    logic [7:0]            w_byte;

    assign w_pkt = pack_cmd(i_output_pattern, i_freq_pattern, i_start, i_stop, i_mode,
                            i_sel_out, i_slow_period, i_fast_period);

`ifdef CHECKSUM_EN
    logic [7:0] r_csum;
    // Buffer is fully shifted out by the checksum slot, so the running XOR is sent instead.
    assign w_byte = (r_cnt == CNT_W'(PACK_NUM)) ? r_csum : r_buf[7:0];
`else
    assign w_byte = r_buf[7:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_buf       <= '0;
            r_tx_data   <= '0;
            r_tx_start  <= 1'b0;
            r_busy      <= 1'b0;
            r_done_tick <= 1'b0;
`ifdef CHECKSUM_EN
            r_csum      <= '0;
`endif
        end else begin
            r_tx_start  <= 1'b0;
            r_done_tick <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start_tick) begin
                        r_buf   <= w_pkt;
                        r_busy  <= 1'b1;
                        r_state <= S_SEND;
`ifdef CHECKSUM_EN
                        r_csum  <= '0;
`endif
                    end
                end
                S_SEND: begin
                    r_tx_data  <= w_byte;
                    r_tx_start <= 1'b1;
                    r_state    <= S_WAIT;
`ifdef CHECKSUM_EN
                    r_csum     <= r_csum ^ w_byte;
`endif
                end
                S_WAIT: begin
                    if (i_tx_done_tick) begin
                        r_buf <= r_buf >> 8;
                        if (r_cnt == LAST_IDX) begin
                            r_state <= S_DONE;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                            r_state <= S_SEND;
                        end
                    end
                end
                S_DONE: begin
                    r_done_tick <= 1'b1;
                    r_cnt       <= '0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_tx_data   = r_tx_data;
    assign o_tx_start  = r_tx_start;
    assign o_busy      = r_busy;
    assign o_done_tick = r_done_tick;

endmodule

// File: tb/tb_encoder.sv
// Randomised bench for encoder: cycle-level event model plus literal packet vectors.
module tb_encoder;

    localparam int DATA_BIT = 32;
    localparam int PACK_NUM = 11;
`ifdef CHECKSUM_EN
    localparam int NB = PACK_NUM + 1;
`else
    localparam int NB = PACK_NUM;
`endif

    typedef logic [7:0] bytes_t [NB];

    logic                clk = 1'b0;
    logic                rst_n;
    logic                i_start_tick;
    logic [DATA_BIT-1:0] i_output_pattern;
    logic [DATA_BIT-1:0] i_freq_pattern;
    logic                i_start, i_stop, i_mode;
    logic [3:0]          i_sel_out;
    logic [7:0]          i_slow_period, i_fast_period;
    logic                i_tx_done_tick;
    logic [7:0]          o_tx_data;
    logic                o_tx_start, o_busy, o_done_tick;

    always #5 clk = ~clk;

    encoder #(.DATA_BIT(DATA_BIT), .PACK_NUM(PACK_NUM)) dut (
        .clk(clk), .rst_n(rst_n), .i_start_tick(i_start_tick),
        .i_output_pattern(i_output_pattern), .i_freq_pattern(i_freq_pattern),
        .i_start(i_start), .i_stop(i_stop), .i_mode(i_mode), .i_sel_out(i_sel_out),
        .i_slow_period(i_slow_period), .i_fast_period(i_fast_period),
        .i_tx_done_tick(i_tx_done_tick), .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
        .o_busy(o_busy), .o_done_tick(o_done_tick)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference packet: field concatenation in wire order, then bytes LSB first.
    function automatic bytes_t model_bytes(input logic [31:0] o, input logic [31:0] f,
                                           input logic st, input logic sp, input logic md,
                                           input logic [3:0] sel, input logic [7:0] sl,
                                           input logic [7:0] fa);
        logic [87:0] v;
        bytes_t      b;
        logic [7:0]  x;
        v = {fa, sl, sel, 1'b0, md, sp, st, f, o};
        x = 8'h00;
        for (int k = 0; k < PACK_NUM; k++) begin
            b[k] = v[8*k +: 8];
            x    = x ^ b[k];
        end
`ifdef CHECKSUM_EN
        b[PACK_NUM] = x;
`endif
        return b;
    endfunction

    // Event model state
    int         cyc = 0;
    int         m_next_start = -1;
    int         m_done_at = -1;
    int         m_left = 0;
    bit         m_busy = 0;
    bit         m_waiting = 0;
    logic [7:0] m_cur = 8'h00;
    logic [7:0] exp_q[$];
    logic [7:0] cap[$];
    int         n_start = 0;
    int         n_done = 0;
    bytes_t     mb;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                check("rst_tx_data", o_tx_data, 0);
                check("rst_tx_start", o_tx_start, 0);
                check("rst_busy", o_busy, 0);
                check("rst_done_tick", o_done_tick, 0);
                m_next_start = -1; m_done_at = -1; m_left = 0;
                m_busy = 0; m_waiting = 0; m_cur = 8'h00;
                exp_q.delete();
            end else begin
                if (cyc == m_done_at) m_busy = 0;
                check("busy", o_busy, m_busy);
                check("tx_start", o_tx_start, cyc == m_next_start);
                check("done_tick", o_done_tick, cyc == m_done_at);
                if (o_tx_start) begin
                    n_start++;
                    cap.push_back(o_tx_data);
                end
                if (o_done_tick) n_done++;
                if (cyc == m_next_start) begin
                    m_waiting = 1;
                    if (exp_q.size() == 0) check("byte_available", 0, 1);
                    else m_cur = exp_q.pop_front();
                end
                check("tx_data", o_tx_data, m_cur);
                if (i_start_tick && !m_busy) begin
                    m_busy = 1;
                    mb = model_bytes(i_output_pattern, i_freq_pattern, i_start, i_stop, i_mode,
                                     i_sel_out, i_slow_period, i_fast_period);
                    exp_q.delete();
                    for (int k = 0; k < NB; k++) exp_q.push_back(mb[k]);
                    m_left = NB;
                    m_next_start = cyc + 2;
                end
                if (i_tx_done_tick && m_waiting) begin
                    m_waiting = 0;
                    m_left--;
                    if (m_left > 0) m_next_start = cyc + 2;
                    else m_done_at = cyc + 2;
                end
            end
        end
    end

    // UART transmitter model: done some cycles after each o_tx_start, plus injectable stray dones.
    int resp_cnt = 0;
    bit resp_rand = 0;
    bit inject = 0;
    initial begin
        i_tx_done_tick = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            i_tx_done_tick = 1'b0;
            if (!rst_n) begin
                resp_cnt = 0;
            end else begin
                if (inject) begin
                    i_tx_done_tick = 1'b1;
                    inject = 0;
                end
                if (resp_cnt > 0) begin
                    resp_cnt--;
                    if (resp_cnt == 0) i_tx_done_tick = 1'b1;
                end
                if (o_tx_start) resp_cnt = resp_rand ? int'($urandom_range(7, 1)) : 5;
            end
        end
    end

    logic [31:0] s_out, s_freq;
    logic        s_st, s_sp, s_md;
    logic [3:0]  s_sel;
    logic [7:0]  s_slow, s_fast;
    bytes_t      lit;
    bytes_t      eb;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [31:0] o, input logic [31:0] f, input logic st,
                              input logic sp, input logic md, input logic [3:0] sel,
                              input logic [7:0] sl, input logic [7:0] fa);
        i_output_pattern = o; i_freq_pattern = f; i_start = st; i_stop = sp; i_mode = md;
        i_sel_out = sel; i_slow_period = sl; i_fast_period = fa;
        s_out = o; s_freq = f; s_st = st; s_sp = sp; s_md = md;
        s_sel = sel; s_slow = sl; s_fast = fa;
    endtask

    task automatic set_random();
        set_fields($urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
                   4'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic scramble();
        i_output_pattern = $urandom; i_freq_pattern = $urandom;
        i_start = 1'($urandom); i_stop = 1'($urandom); i_mode = 1'($urandom);
        i_sel_out = 4'($urandom); i_slow_period = 8'($urandom); i_fast_period = 8'($urandom);
    endtask

    task automatic clear_counts();
        cap.delete();
        n_start = 0;
        n_done = 0;
    endtask

    task automatic pulse_start();
        clear_counts();
        i_start_tick = 1'b1;
        tick();
        i_start_tick = 1'b0;
    endtask

    task automatic wait_done(input string name, input bit scr);
        int k;
        k = 0;
        while (!(n_done > 0 && !o_busy) && k < 1000) begin
            tick();
            if (scr) scramble();
            k++;
        end
        if (k >= 1000) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_starts(input string name, input int n);
        int k;
        k = 0;
        while (n_start < n && k < 500) begin
            tick();
            k++;
        end
        if (k >= 500) check({name, "_start_timeout"}, 0, 1);
    endtask

    // Byte list, pulse counts and a decoder-side unpack of the captured bytes.
    task automatic check_pkt(input string name, input bytes_t exp);
        logic [87:0] v;
        check({name, "_n_start"}, n_start, NB);
        check({name, "_n_done"}, n_done, 1);
        v = '0;
        for (int k = 0; k < NB; k++) begin
            if (k < cap.size()) begin
                check($sformatf("%s_byte%0d", name, k), cap[k], exp[k]);
                if (k < PACK_NUM) v[8*k +: 8] = cap[k];
            end
        end
        check({name, "_dec_out"}, v[31:0], s_out);
        check({name, "_dec_freq"}, v[63:32], s_freq);
        check({name, "_dec_flags"}, v[67:64], {1'b0, s_md, s_sp, s_st});
        check({name, "_dec_sel"}, v[71:68], s_sel);
        check({name, "_dec_slow"}, v[79:72], s_slow);
        check({name, "_dec_fast"}, v[87:80], s_fast);
    endtask

    initial begin
        rst_n = 1'b0;
        i_start_tick = 1'b0;
        set_fields(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

`ifdef CHECKSUM_EN
        lit = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h5A, 8'h5A, 8'hA5, 8'hA5, 8'h95, 8'h10, 8'h02, 8'hC3};
`else
        lit = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h5A, 8'h5A, 8'hA5, 8'hA5, 8'h95, 8'h10, 8'h02};
`endif
        eb = model_bytes(32'h11223344, 32'hA5A55A5A, 1'b1, 1'b0, 1'b1, 4'h9, 8'h10, 8'h02);
        for (int k = 0; k < NB; k++) check($sformatf("model_lit%0d", k), eb[k], lit[k]);

        // Single packet with the reference vector
        set_fields(32'h11223344, 32'hA5A55A5A, 1'b1, 1'b0, 1'b1, 4'h9, 8'h10, 8'h02);
        pulse_start();
        wait_done("single", 1'b0);
        check_pkt("single", lit);

        // Second start during byte 3 must be dropped
        set_fields(32'h11223344, 32'hA5A55A5A, 1'b1, 1'b0, 1'b1, 4'h9, 8'h10, 8'h02);
        pulse_start();
        wait_starts("busy", 3);
        i_output_pattern = 32'hFFFFFFFF;
        i_start_tick = 1'b1;
        tick();
        i_start_tick = 1'b0;
        wait_done("busy", 1'b0);
        check_pkt("busy", lit);

        // Stray done while idle
        clear_counts();
        inject = 1;
        repeat (3) tick();
        check("stray_idle_busy", o_busy, 0);
        check("stray_idle_starts", n_start, 0);

        // Stray done in the send cycle
        set_random();
        clear_counts();
        i_start_tick = 1'b1;
        #2;
        inject = 1;
        @(posedge clk);
        #1;
        i_start_tick = 1'b0;
        wait_done("stray_send", 1'b0);
        check_pkt("stray_send", model_bytes(s_out, s_freq, s_st, s_sp, s_md, s_sel, s_slow, s_fast));

        // Reset after byte 6 aborts the packet
        set_random();
        pulse_start();
        wait_starts("abort", 6);
        repeat (2) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        check("abort_tx_data", o_tx_data, 0);
        check("abort_tx_start", o_tx_start, 0);
        check("abort_busy", o_busy, 0);
        check("abort_done", n_done, 0);
        rst_n = 1'b1;
        tick();
        set_random();
        pulse_start();
        wait_done("after_abort", 1'b0);
        check_pkt("after_abort", model_bytes(s_out, s_freq, s_st, s_sp, s_md, s_sel, s_slow, s_fast));

        // Random packets, random handshake delay, inputs churning while busy
        resp_rand = 1;
        for (int p = 0; p < 15; p++) begin
            set_random();
            pulse_start();
            wait_done("rand", 1'b1);
            check_pkt($sformatf("rand%0d", p),
                      model_bytes(s_out, s_freq, s_st, s_sp, s_md, s_sel, s_slow, s_fast));
            repeat ($urandom_range(2, 0)) tick();
        end

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1);
    end

endmodule

// File: doc/encoder.md
Name: encoder

Overview:
- Transmit-side counterpart of the UART command decoder.
- Latches one command word (output pattern, frequency pattern, control flags, channel select, slow/fast periods) on a start tick.
- Serialises the word into PACK_NUM bytes, least-significant byte first, and hands them one at a time to the UART transmitter via a start/done handshake.
- Used to echo or report pattern/config state back to the host, byte-compatible with the decoder's packet layout.

Parameters:
- DATA_BIT, 32, width of output pattern and frequency pattern.
- PACK_NUM, 11, payload bytes per packet; must satisfy 8*PACK_NUM >= 2*DATA_BIT+24.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- i_start_tick  input  1  one-cycle request to send a packet
- i_output_pattern  input  DATA_BIT  output pattern field
- i_freq_pattern  input  DATA_BIT  frequency pattern field
- i_start  input  1  start flag
- i_stop  input  1  stop flag
- i_mode  input  1  mode flag
- i_sel_out  input  4  output channel select
- i_slow_period  input  8  slow period
- i_fast_period  input  8  fast period
- i_tx_done_tick  input  1  UART transmitter finished current byte
- o_tx_data  output  8  byte to transmit
- o_tx_start  output  1  one-cycle pulse: load o_tx_data into transmitter
- o_busy  output  1  packet in progress
- o_done_tick  output  1  one-cycle pulse: packet complete

Behaviour:
- Packet bit layout, P = 2*DATA_BIT:
  - [DATA_BIT-1:0] output pattern
  - [P-1:DATA_BIT] freq pattern
  - [P] start, [P+1] stop, [P+2] mode, [P+3] 0
  - [P+7:P+4] sel_out, [P+15:P+8] slow period, [P+23:P+16] fast period
  - remaining upper bits 0
- Byte k on the wire = packet bits [8k+7:8k], k = 0..PACK_NUM-1.
- All outputs registered. Reset values: o_tx_data=0, o_tx_start=0, o_busy=0, o_done_tick=0, state S_IDLE, byte count 0, buffer 0.
- States:
  - S_IDLE:
    - On i_start_tick: latch all inputs into buffer, go S_SEND, o_busy=1 next cycle.
    - Otherwise remain.
  - S_SEND:
    - Drive o_tx_data = buffer[7:0] and pulse o_tx_start for exactly one cycle.
    - Go S_WAIT.
  - S_WAIT:
    - On i_tx_done_tick: shift buffer right 8, count+1.
    - If count == PACK_NUM-1 (last byte done): go S_DONE.
    - Otherwise go S_SEND.
  - S_DONE:
    - Pulse o_done_tick for one cycle, clear count, o_busy=0.
    - Return S_IDLE.
- Latency:
  - i_start_tick at cycle 0 → o_tx_start high at cycle 2.
  - i_tx_done_tick at cycle n → next o_tx_start at cycle n+2.
  - Last done at cycle n → o_done_tick at cycle n+2.
- o_tx_data holds its value from its o_tx_start until the next byte's o_tx_start.
- Boundary conditions:
  - i_start_tick while not S_IDLE is ignored; no queuing.
  - Input changes after the latch cycle do not affect the packet in flight.
  - i_tx_done_tick outside S_WAIT is ignored.
  - i_start_tick in the same cycle as the S_DONE→S_IDLE transition is ignored; the bench must wait for o_busy=0.
  - Reset mid-packet aborts immediately: outputs at reset values, no o_done_tick.
  - Byte counter width is $clog2(PACK_NUM+1), so it never wraps within a packet.

Optional Feature:
- Macro CHECKSUM_EN.
- Defined:
  - After the PACK_NUM payload bytes, send one extra byte = XOR of all payload bytes, accumulated as each byte is sent.
  - Packet length becomes PACK_NUM+1.
  - o_done_tick follows the checksum byte's done.
- Undefined: exactly PACK_NUM bytes, no accumulator logic.

Decomposition:
- Shared package (also used by the decoder):
  - state encodings
  - PACK_BIT = 8*PACK_NUM
  - FREQ_INDEX = 2*DATA_BIT
  - field offsets (START_OFS=0, STOP_OFS=1, MODE_OFS=2, SEL_OFS=4, SLOW_OFS=8, FAST_OFS=16, relative to FREQ_INDEX)
- No sub-module required.
- Packet assembly is a small function in the package so encoder and decoder cannot diverge.

Test Plan:
- Single packet:
  - Stimulus: output=32'h11223344, freq=32'hA5A55A5A, start=1, stop=0, mode=1, sel=4'h9, slow=8'h10, fast=8'h02.
  - Bench model returns tx_done 5 cycles after each o_tx_start.
  - Required: bytes 44,33,22,11,5A,5A,A5,A5,95,10,02, then one o_done_tick.
- Loopback:
  - Feed o_tx_data/o_tx_start into a decoder instance through a UART model.
  - Required: decoder outputs equal the encoder inputs, including sel_out=9 and fast=02.
- Busy rejection:
  - Stimulus: second i_start_tick with output=32'hFFFFFFFF during byte 3.
  - Required: first packet bytes unchanged; exactly 11 o_tx_start pulses and one o_done_tick.
- Stray done:
  - Stimulus: i_tx_done_tick pulsed in S_IDLE and in S_SEND.
  - Required: no state change, no extra bytes, count unaffected.
- Reset abort:
  - Stimulus: rst_n low after byte 6.
  - Required: all outputs 0, no o_done_tick.
  - A new start tick after reset sends a full 11 bytes from byte 0.
- CHECKSUM_EN:
  - Stimulus: repeat the single-packet vector.
  - Required: 12th byte = XOR of the 11 payload bytes; o_done_tick only after the 12th done.
